// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, read-mode enum, status struct and helper for the flexible FIFO
//   DATA_WIDTH / FIFO_DEPTH : default entry width and depth for fifo_flex and its interface
//   rd_mode_e               : read-port flavour (show-ahead or registered)
//   status_t                : packed occupancy/error flags
//   is_pow2()               : depth legality check used at elaboration
package fifo_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FIFO_DEPTH = 8;

    typedef enum logic {RD_SHOW_AHEAD, RD_REGISTERED} rd_mode_e;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } status_t;

    function automatic bit is_pow2(input int n);
        return n >= 2 && (n & (n - 1)) == 0;
    endfunction

endpackage

// File: rtl/fifo_flex_if.sv
// fifo_flex_if: handshake, data and status bundle between a FIFO user and fifo_flex
//   master : drives flush, wr_en, wr_data, rd_en, clr_err; observes read data and status
//   slave  : the FIFO side, the mirror image of master
interface fifo_flex_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH = fifo_pkg::FIFO_DEPTH
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic                  flush;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [PW:0]           count;
    logic                  overflow;
    logic                  underflow;
    logic                  clr_err;

    modport master (
        output flush, wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: storage array with one synchronous write port and one asynchronous read port
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH = fifo_pkg::FIFO_DEPTH,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_flex.sv
// fifo_flex: parametrised synchronous FIFO with show-ahead or registered read, level flags,
//            occupancy count, synchronous flush and sticky overflow/underflow errors
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fifo_flex_if slave port carrying flush, wr_en/wr_data, rd_en/rd_data/rd_valid,
//           full, empty, almost_full, almost_empty, count, overflow, underflow, clr_err
module fifo_flex
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = fifo_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH    = fifo_pkg::FIFO_DEPTH,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 2,
    parameter int SHOW_AHEAD    = 1
) (
    input logic         clk,
    input logic         rst_n,
    fifo_flex_if.slave  bus
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam rd_mode_e MODE = (SHOW_AHEAD != 0) ? RD_SHOW_AHEAD : RD_REGISTERED;
    localparam logic [PW:0] DEPTH_W = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0] AF_W    = (PW+1)'(AFULL_THRESH);
    localparam logic [PW:0] AE_W    = (PW+1)'(AEMPTY_THRESH);
    localparam logic [PW:0] ONE     = (PW+1)'(1);

    if (!is_pow2(FIFO_DEPTH)) begin : g_bad_depth
        $fatal(1, "fifo_flex: FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
        $fatal(1, "fifo_flex: DATA_WIDTH must be >= 1");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH) begin : g_bad_af
        $fatal(1, "fifo_flex: AFULL_THRESH out of range 1..FIFO_DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > FIFO_DEPTH - 1) begin : g_bad_ae
        $fatal(1, "fifo_flex: AEMPTY_THRESH out of range 0..FIFO_DEPTH-1");
    end

    // One extra pointer bit distinguishes full from empty when the indices coincide.
    logic [PW:0]           r, w, cnt, r_inc, w_inc;
    logic                  wr_ok, rd_ok, ovf, udf;
    logic [DATA_WIDTH-1:0] head;
    status_t               st;

    assign cnt   = w - r;
    assign r_inc = r + ONE;
    assign w_inc = w + ONE;

    assign st.full         = cnt == DEPTH_W;
    assign st.empty        = cnt == '0;
    assign st.almost_full  = cnt >= AF_W;
    assign st.almost_empty = cnt <= AE_W;
    assign st.overflow     = ovf;
    assign st.underflow    = udf;

    // Flush overrides both requests, so neither moves a pointer nor raises an error.
    assign wr_ok = bus.wr_en && !st.full && !bus.flush;
    assign rd_ok = bus.rd_en && !st.empty && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= '0;
            w <= '0;
        end else if (bus.flush) begin
            r <= '0;
            w <= '0;
        end else begin
            if (wr_ok) w <= w_inc;
            if (rd_ok) r <= r_inc;
        end
    end

    // Sticky errors: a set in the same cycle as clr_err wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= (bus.wr_en && st.full && !bus.flush) || (ovf && !bus.clr_err);
            udf <= (bus.rd_en && st.empty && !bus.flush) || (udf && !bus.clr_err);
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (w[PW-1:0]),
        .wdata (bus.wr_data),
        .raddr (r[PW-1:0]),
        .rdata (head)
    );

    if (MODE == RD_REGISTERED) begin : g_reg
        logic [DATA_WIDTH-1:0] rd_q;
        logic                  rv_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q <= '0;
                rv_q <= 1'b0;
            end else begin
                rv_q <= rd_ok;
                if (rd_ok) rd_q <= head;
            end
        end
        assign bus.rd_data  = rd_q;
        assign bus.rd_valid = rv_q;
    end else begin : g_sa
        assign bus.rd_data  = head;
        assign bus.rd_valid = !st.empty;
    end

    assign bus.full         = st.full;
    assign bus.empty        = st.empty;
    assign bus.almost_full  = st.almost_full;
    assign bus.almost_empty = st.almost_empty;
    assign bus.overflow     = st.overflow;
    assign bus.underflow    = st.underflow;
    assign bus.count        = cnt;

    a_count_range: assert property (@(posedge clk) disable iff (!rst_n) cnt <= DEPTH_W);
    a_wr_blocked:  assert property (@(posedge clk) disable iff (!rst_n) !bus.flush && !wr_ok |=> $stable(w));
    a_rd_blocked:  assert property (@(posedge clk) disable iff (!rst_n) !bus.flush && !rd_ok |=> $stable(r));
    a_wr_advance:  assert property (@(posedge clk) disable iff (!rst_n) wr_ok |=> w == $past(w_inc));
    a_rd_advance:  assert property (@(posedge clk) disable iff (!rst_n) rd_ok |=> r == $past(r_inc));
    a_flush_empty: assert property (@(posedge clk) disable iff (!rst_n) bus.flush |=> st.empty);
    a_reset_clear: assert property (@(posedge clk) $rose(rst_n) |-> r == '0 && w == '0 && !ovf && !udf);

endmodule
